// File: rtl/vmat_reader_pkg.sv
// vmat_reader_pkg -- shared definitions for the result-matrix reader.
//   state_e    : FSM state encoding (also exported on the debug port)
//   ELEM_BYTES : byte stride between consecutive matrix elements
//   is_last    : true when (row, col) is the final element of a rows x cols matrix
package vmat_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned ELEM_BYTES = 4;

    function automatic logic is_last(input logic [31:0] row, input logic [31:0] col,
                                     input logic [31:0] rows, input logic [31:0] cols);
        return (row == rows - 32'd1) && (col == cols - 32'd1);
    endfunction

endpackage

// File: rtl/vmat_reader_if.sv
// vmat_reader_if -- memory read port and element output stream of the reader.
//   mem_re / mem_addr : read strobe and byte address (reader -> memory)
//   mem_rdata         : read data, valid exactly one cycle after mem_re
//   out_*             : element stream. A beat transfers on a cycle where
//                       out_valid and out_ready are both 1; while out_valid=1
//                       and out_ready=0 the payload (data/row/col/last) is held.
//   master modport: the reader; slave modport: memory model / consumer.
interface vmat_reader_if #(
    parameter int DATA_W = 32
);
    logic              mem_re;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_row;
    logic [31:0]       out_col;
    logic              out_last;

    modport master (
        output mem_re, mem_addr,
        input  mem_rdata,
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_re, mem_addr,
        output mem_rdata,
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/vmat_reader_vfifo.sv
// vfifo -- small synchronous FIFO used as the reader's output buffer.
//   push/push_data : write an entry (accepted when not full, or full with pop)
//   pop/pop_data   : pop_data is the head entry; pop removes it when non-empty
//   empty, count   : occupancy status
module vfifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A push into a full FIFO is fine when the head leaves in the same cycle.
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/vmat_reader.sv
// vmat_reader -- drains a row-major result matrix C from memory and streams
// its elements out with their (row, col) index.
//   clk, reset        : clock, asynchronous active-low reset
//   start             : launch a drain (ignored unless idle)
//   base_addr         : byte address of C[0][0]
//   num_rows/num_cols : dimensions of C, 4-byte elements
//   busy, done        : drain in progress / one-cycle completion pulse
//   dbg_state         : current FSM state
//   bus (master)      : memory read port and element output stream
module vmat_reader
    import vmat_reader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   base_addr,
    input  logic [31:0]   num_rows,
    input  logic [31:0]   num_cols,
    output logic          busy,
    output logic          done,
    output state_e        dbg_state,
    vmat_reader_if.master bus
);

    localparam int E_W   = DATA_W + 65;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]  state_q, state_d;
    logic [31:0] row_q, row_d, col_q, col_d;
    logic [31:0] rows_q, rows_d, cols_q, cols_d;
    logic [31:0] addr_q, addr_d;
    logic        inflight_q, inflight_d;
    logic [31:0] pend_row_q, pend_row_d, pend_col_q, pend_col_d;
    logic        pend_last_q, pend_last_d;

    logic             mem_re;
    logic             credit_ok;
    logic             fifo_pop, fifo_empty, out_valid;
    logic [CNT_W-1:0] fifo_count;
    logic [E_W-1:0]   fifo_wdata, fifo_rdata;
    logic             head_last;

    // FIFO entry layout: {last, row, col, data}
    assign fifo_wdata = {pend_last_q, pend_row_q, pend_col_q, bus.mem_rdata};
    assign head_last  = fifo_rdata[E_W-1];
    assign out_valid  = !fifo_empty;
    assign fifo_pop   = out_valid && bus.out_ready;

    // The entry popped this cycle frees its slot, so it is credited back
    // before deciding on a new read; this keeps one read per cycle while the
    // consumer is ready, and the returning data can never overflow the FIFO.
    assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < (32'(FIFO_DEPTH) + 32'(fifo_pop));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        addr_d      = addr_q;
        pend_row_d  = pend_row_q;
        pend_col_d  = pend_col_q;
        pend_last_d = pend_last_q;
        inflight_d  = 1'b0;
        mem_re      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d  = num_rows;
                    cols_d  = num_cols;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = base_addr;
                    state_d = (num_rows == '0 || num_cols == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (credit_ok) begin
                    mem_re      = 1'b1;
                    inflight_d  = 1'b1;
                    pend_row_d  = row_q;
                    pend_col_d  = col_q;
                    pend_last_d = is_last(row_q, col_q, rows_q, cols_q);
                    // Row-major order makes the address a running +4 stride,
                    // equal to base + ((row*cols + col) << 2) mod 2^32.
                    addr_d      = addr_q + 32'(ELEM_BYTES);
                    if (pend_last_d) begin
                        state_d = S_DRAIN;
                    end else if (col_q == cols_q - 32'd1) begin
                        col_d = '0;
                        row_d = row_q + 32'd1;
                    end else begin
                        col_d = col_q + 32'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_pop && head_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // inflight_q clears on reset, so a read returning after reset is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            pend_row_q  <= '0;
            pend_col_q  <= '0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            pend_row_q  <= pend_row_d;
            pend_col_q  <= pend_col_d;
            pend_last_q <= pend_last_d;
        end
    end

    vfifo #(
        .WIDTH(E_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (inflight_q),
        .push_data(fifo_wdata),
        .pop      (fifo_pop),
        .pop_data (fifo_rdata),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_e'(state_q);

    // Address and payload are forced to zero when not qualified so the bus
    // is quiet in idle and during reset.
    assign bus.mem_re    = mem_re;
    assign bus.mem_addr  = mem_re ? addr_q : '0;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_valid && head_last;
    assign bus.out_row   = out_valid ? fifo_rdata[E_W-2 -: 32] : '0;
    assign bus.out_col   = out_valid ? fifo_rdata[DATA_W+31 -: 32] : '0;
    assign bus.out_data  = out_valid ? fifo_rdata[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_vmat_reader.sv
// tb_vmat_reader -- self-checking bench for vmat_reader: directed matrix
// drains, stalls, degenerate sizes, mid-drain reset and random matrices,
// all checked against an element list computed from the matrix geometry.
module tb_vmat_reader;
    import vmat_reader_pkg::*;

    localparam int DW     = 32;
    localparam int DEPTH  = 2;
    localparam int BEAT_W = 1 + 32 + 32 + DW;

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] num_rows  = '0;
    logic [31:0] num_cols  = '0;
    logic        busy, done;
    state_e      dbg_state;

    always #5 clk = ~clk;

    vmat_reader_if #(.DATA_W(DW)) bus ();

    vmat_reader #(
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .num_rows (num_rows),
        .num_cols (num_cols),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state),
        .bus      (bus)
    );

    // ---------------- scoreboard state ----------------
    int                n_vec = 0;
    int                n_err = 0;
    int                cyc   = 0;
    logic [BEAT_W-1:0] exp_q[$];
    logic [31:0]       addr_q[$];
    int                n_reads, n_beats, n_valid, done_cnt;
    int                first_re_cyc, first_valid_cyc, last_re_cyc, last_xfer_cyc, done_cyc;
    int                mode;
    bit                chk_en     = 1'b0;
    bit                prev_stall = 1'b0;
    logic [BEAT_W-1:0] prev_beat;
    logic [31:0]       salt = 32'h1234_5678;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory contents: a fixed hash of the byte address, salted per test.
    function automatic logic [DW-1:0] mem_func(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Memory model: data appears the cycle after the read strobe; junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_re === 1'b1) bus.mem_rdata <= mem_func(bus.mem_addr);
        else                     bus.mem_rdata <= $urandom;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [BEAT_W-1:0] cur;
        logic              xfer;
        int                outstanding;
        if (reset !== 1'b1 || !chk_en) begin
            prev_stall = 1'b0;
        end else begin
            cur  = {bus.out_last, bus.out_row, bus.out_col, bus.out_data};
            xfer = bus.out_valid && bus.out_ready;
            if (bus.mem_re) begin
                // Elements read but not yet delivered, counting this cycle's beat as gone.
                outstanding = n_reads - n_beats - (xfer ? 1 : 0);
                check("fifo_space", outstanding < DEPTH, 1);
                if (addr_q.size() == 0) check("extra_read", 1, 0);
                else                    check("mem_addr", bus.mem_addr, addr_q.pop_front());
                if (n_reads == 0)   first_re_cyc = cyc;
                else if (mode == 0) check("read_gap", cyc - last_re_cyc, 1);
                last_re_cyc = cyc;
                n_reads++;
            end
            if (bus.out_valid) begin
                if (n_valid == 0) first_valid_cyc = cyc;
                n_valid++;
            end else begin
                check("last_without_valid", bus.out_last, 0);
            end
            if (prev_stall) check("stall_hold", cur, prev_beat);
            if (xfer) begin
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else                   check("beat", cur, exp_q.pop_front());
                n_beats++;
                if (bus.out_last) last_xfer_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_beat  = cur;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic ready_for(input int m, input int i);
        if (m == 0) return 1'b1;
        if (m == 1) return ((i % 4) == 0) || ((i % 4) == 3);
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_mem_re"},    bus.mem_re, 0);
        check({tag, "_mem_addr"},  bus.mem_addr, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"},  bus.out_data, 0);
        check({tag, "_out_row"},   bus.out_row, 0);
        check({tag, "_out_col"},   bus.out_col, 0);
        check({tag, "_out_last"},  bus.out_last, 0);
        check({tag, "_state"},     dbg_state, ST_IDLE);
    endtask

    // Runs one drain of an r x c matrix at base b.
    //   m        : out_ready pattern (0 always, 1 = 1,0,0,1 repeating, 2 random)
    //   poke     : pulse start again while the drain is busy
    //   abort_at : assert reset once this many beats have transferred (0 = never)
    task automatic run_matrix(input logic [31:0] b, input logic [31:0] r, input logic [31:0] c,
                              input int m, input bit poke, input int abort_at);
        int total;
        int limit;
        bit finished;
        bit aborted;
        exp_q.delete();
        addr_q.delete();
        for (int rr = 0; rr < int'(r); rr++) begin
            for (int cc = 0; cc < int'(c); cc++) begin
                logic [31:0] a;
                logic        l;
                a = b + ((32'(rr) * c + 32'(cc)) * 32'd4);
                l = (rr == int'(r) - 1) && (cc == int'(c) - 1);
                addr_q.push_back(a);
                exp_q.push_back({l, 32'(rr), 32'(cc), mem_func(a)});
            end
        end
        total    = int'(r) * int'(c);
        limit    = total * 8 + 40;
        n_reads  = 0;
        n_beats  = 0;
        n_valid  = 0;
        done_cnt = 0;
        mode     = m;
        finished = 1'b0;
        aborted  = 1'b0;
        chk_en   = 1'b1;

        @(posedge clk); #1;
        start         = 1'b1;
        base_addr     = b;
        num_rows      = r;
        num_cols      = c;
        bus.out_ready = ready_for(m, 0);
        @(posedge clk); #1;
        start     = 1'b0;
        // Scramble the inputs: the drain must use the latched values.
        base_addr = $urandom;
        num_rows  = $urandom;
        num_cols  = $urandom;
        for (int i = 0; i < limit; i++) begin
            bus.out_ready = ready_for(m, i + 1);
            start         = poke && (i == 1);
            if (abort_at > 0 && n_beats >= abort_at) begin
                reset = 1'b0;
                #1;
                check_zero("abort");
                chk_en = 1'b0;
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                exp_q.delete();
                addr_q.delete();
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            repeat (2) begin
                @(posedge clk); #1;
            end
            if (!finished) check("timeout", 0, 1);
            check("beat_count", n_beats, total);
            check("read_count", n_reads, total);
            check("beats_left", exp_q.size(), 0);
            check("done_pulses", done_cnt, 1);
            check("busy_after", busy, 0);
            if (total == 0) check("zero_valid", n_valid, 0);
            if (m == 0 && total > 0) begin
                check("first_valid_latency", first_valid_cyc - first_re_cyc, 2);
                check("done_latency", done_cyc - last_xfer_cyc, 1);
            end
        end
        chk_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.out_ready = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;

        run_matrix(32'h0000_0100, 2, 3, 0, 1'b0, 0);
        run_matrix(32'h0000_0100, 2, 3, 1, 1'b0, 0);
        run_matrix(32'h0000_0200, 0, 5, 0, 1'b0, 0);
        run_matrix(32'h0000_0200, 4, 0, 0, 1'b0, 0);
        run_matrix(32'h0000_0300, 1, 1, 0, 1'b1, 0);
        run_matrix(32'h0000_0400, 4, 4, 0, 1'b0, 3);
        run_matrix(32'h0000_0400, 4, 4, 0, 1'b0, 0);

        for (int t = 0; t < 20; t++) begin
            logic [31:0] b;
            salt = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            run_matrix(b, 32'($urandom_range(0, 4)), 32'($urandom_range(0, 5)),
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vmat_reader.md
VMAT_READER -- requirements
Module: vmat_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning element width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning output buffer entries (minimum 2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports clk (in, 1, rising-edge clock) and reset (in, 1, asynchronous active-low reset).
REQ-004 SHALL have ports start (in, 1, launch a drain of result matrix C) and base_addr (in, 32, byte address of C[0][0]).
REQ-005 SHALL have ports num_rows and num_cols (in, 32 each, dimensions of C, row-major, 4-byte elements).
REQ-006 SHALL have ports busy (out, 1, drain in progress) and done (out, 1, one-cycle completion pulse).
REQ-007 SHALL have ports mem_re (out, 1, read strobe) and mem_addr (out, 32, read byte address).
REQ-008 SHALL have port mem_rdata (in, DATA_W, data valid exactly one cycle after mem_re).
REQ-009 SHALL have ports out_valid (out, 1), out_ready (in, 1) and out_data (out, DATA_W): element stream.
REQ-010 SHALL have ports out_row and out_col (out, 32 each, index of out_data) and out_last (out, 1, final element).

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-012 IDLE: start=1 SHALL latch base_addr, num_rows and num_cols, clear row and col to 0, and enter RUN; busy=1 from the next cycle.
REQ-013 If start is seen in IDLE with num_rows=0 or num_cols=0, the block SHALL go straight to DONE with no mem_re and no out_valid.
REQ-014 start SHALL be ignored outside IDLE; latched dimensions SHALL NOT change mid-drain.
REQ-015 RUN: mem_addr SHALL equal base + ((row*num_cols + col) << 2), truncated to 32 bits.
REQ-016 RUN: mem_re SHALL assert only when (FIFO occupancy + reads in flight) < FIFO_DEPTH.
REQ-017 Index order: col increments per issued read; at num_cols-1, col wraps to 0 and row increments.
REQ-018 Issuing the read for (num_rows-1, num_cols-1) SHALL move the FSM to DRAIN.
REQ-019 Each returned mem_rdata SHALL be pushed into the FIFO together with its row, col and last flag.
REQ-020 The FIFO SHALL never overflow; simultaneous push and pop SHALL be legal at full and at empty.
REQ-021 out_valid SHALL equal FIFO non-empty; a beat transfers when out_valid and out_ready are both 1.
REQ-022 out_data, out_row, out_col and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 With out_ready held at 1, throughput SHALL be one element per cycle; first out_valid comes 2 cycles after the first mem_re.
REQ-024 DRAIN -> DONE SHALL occur on transfer of the out_last beat; DONE SHALL pulse done=1 for one cycle, then return to IDLE with busy=0.
REQ-025 out_last SHALL be 1 only on element (num_rows-1, num_cols-1).

Reset
REQ-026 While reset=0, state SHALL be IDLE, FIFO empty, and busy, done, mem_re, out_valid and out_last=0; mem_addr, out_data, out_row and out_col SHALL be 0.
REQ-027 Reset mid-drain SHALL abort immediately; a read returning after reset is released SHALL be discarded.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the ELEM_BYTES=4 constant.
REQ-029 The output buffer SHALL be a separate sub-module vfifo (parameterised width and depth, count output).

Verification
REQ-030 Bench: 2x3 matrix at base 0x100, out_ready=1 -> mem_addr 0x100, 0x104 … 0x114 on consecutive cycles; 6 beats in order (0,0)..(1,2); out_last on beat 6; done 1 cycle later.
REQ-031 Bench: same matrix with out_ready toggling 1,0,0,1 -> no lost or duplicated beats, outputs stable while stalled, mem_re never exceeds FIFO space.
REQ-032 Bench: start with num_rows=0 (and separately num_cols=0) -> done pulse, zero mem_re, zero out_valid.
REQ-033 Bench: 1x1 matrix -> single beat with out_last=1 and row=col=0; start pulsed during busy is ignored.
REQ-034 Bench: reset=0 asserted after the third beat of a 4x4 drain -> all outputs 0 immediately; a fresh start afterwards yields a full 16 beats.
